mux_select_sequencer: RTL

//  Upstream driver for the 8:1 mux stage. Captures one 8-bit data word with a valid/ready handshake.

---
 rtl/mux_select_sequencer.sv | 102 ++++++++++
 1 files changed

// File: rtl/mux_select_sequencer.sv
// Captures one data word and steps the 8:1 mux select through all values, HOLD clocks each.
// Latency: sel_valid one clock after accept; in_ready only in IDLE, so new words are refused while busy.
module mux_select_sequencer #(
  parameter int HOLD = 1,
  parameter bit DIR  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [0:7] din,
  input  logic       abort,
  output logic [0:7] w_out,
  output logic [0:2] sel,
  output logic       sel_valid,
  output logic       exp_f,
  output logic       done
);

  if (HOLD < 1) begin : g_bad_hold
    $error("mux_select_sequencer: HOLD must be at least 1");
  end

  localparam int              CW        = $clog2(HOLD) + 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(HOLD - 1);
  localparam logic [2:0]      SEL_FIRST = DIR ? 3'd7 : 3'd0;
  localparam logic [2:0]      SEL_LAST  = DIR ? 3'd0 : 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [0:7]    w_q;
  logic [2:0]    sel_q;
  logic [2:0]    sel_d;
  logic [CW-1:0] cnt_q;
  logic          sel_valid_q;
  logic          done_q;

  always_comb begin
    sel_d = DIR ? (sel_q - 3'd1) : (sel_q + 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      w_q         <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      sel_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            w_q         <= din;
            sel_q       <= SEL_FIRST;
            cnt_q       <= '0;
            sel_valid_q <= 1'b1;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          // Abort wins even on the final hold cycle, so no done pulse is produced.
          if (abort) begin
            sel_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (sel_q == SEL_LAST) begin
              sel_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              sel_q <= sel_d;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign w_out     = w_q;
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign done      = done_q;
  assign exp_f     = w_q[sel_q];

endmodule
